// File: rtl/fft_sched.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT: one butterfly per cycle,
// write-back addresses delayed to match the butterfly datapath, pipeline drained between stages.
module fft_sched #(
   parameter int unsigned N_POINTS   = 512,
   parameter int unsigned ADDR_W     = $clog2(N_POINTS),
   parameter int unsigned BF_LATENCY = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      rd_en_o,
   output logic [ADDR_W-1:0]         rd_addr_a_o,
   output logic [ADDR_W-1:0]         rd_addr_b_o,
   output logic [ADDR_W-2:0]         tw_addr_o,
   output logic                      wr_en_o,
   output logic [ADDR_W-1:0]         wr_addr_a_o,
   output logic [ADDR_W-1:0]         wr_addr_b_o,
   output logic [$clog2(ADDR_W):0]   stage_o
);

   localparam int unsigned SW = $clog2(ADDR_W) + 1;
   localparam int unsigned KW = ADDR_W - 1;
   localparam int unsigned DW = $clog2(BF_LATENCY + 1);
   localparam logic [KW-1:0] K_LAST = KW'(N_POINTS / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(ADDR_W - 1);
   localparam logic [DW-1:0] D_LAST = DW'(BF_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nx;
   logic [SW-1:0]     s, s_nx;
   logic [KW-1:0]     k, k_nx;
   logic [DW-1:0]     dcnt, dcnt_nx;

   logic [ADDR_W-1:0] kx, half, pos, grp, addr_a;

   logic [BF_LATENCY-1:0] dv;
   logic [ADDR_W-1:0]     da [BF_LATENCY];
   logic [ADDR_W-1:0]     db [BF_LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= '0;
         k     <= '0;
         dcnt  <= '0;
      end else begin
         state <= state_nx;
         s     <= s_nx;
         k     <= k_nx;
         dcnt  <= dcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      s_nx     = s;
      k_nx     = k;
      dcnt_nx  = dcnt;
      busy_o   = (state != IDLE);
      done_o   = (state == DONE);
      rd_en_o  = (state == RUN);
      unique case (state)
         IDLE: begin
            if (start_i) begin
               state_nx = RUN;
               s_nx     = '0;
               k_nx     = '0;
            end
         end
         RUN: begin
            if (k == K_LAST) begin
               state_nx = DRAIN;
               k_nx     = '0;
               dcnt_nx  = '0;
            end else begin
               k_nx = k + KW'(1);
            end
         end
         DRAIN: begin
            if (dcnt == D_LAST) begin
               dcnt_nx = '0;
               if (s < S_LAST) begin
                  s_nx     = s + SW'(1);
                  state_nx = RUN;
               end else begin
                  state_nx = DONE;
               end
            end else begin
               dcnt_nx = dcnt + DW'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
            s_nx     = '0;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Top operand sits at grp*2*half + pos; the twiddle exponent scales pos up to the N-point grid.
   always_comb begin
      kx          = {1'b0, k};
      half        = ADDR_W'(1) << s;
      pos         = kx & (half - ADDR_W'(1));
      grp         = kx >> s;
      addr_a      = (grp << (s + SW'(1))) + pos;
      rd_addr_a_o = '0;
      rd_addr_b_o = '0;
      tw_addr_o   = '0;
      if (state == RUN) begin
         rd_addr_a_o = addr_a;
         rd_addr_b_o = addr_a + half;
         tw_addr_o   = (ADDR_W-1)'(pos << (S_LAST - s));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv <= '0;
         for (int unsigned i = 0; i < BF_LATENCY; i++) begin
            da[i] <= '0;
            db[i] <= '0;
         end
      end else begin
         dv[0] <= rd_en_o;
         da[0] <= rd_addr_a_o;
         db[0] <= rd_addr_b_o;
         for (int unsigned i = 1; i < BF_LATENCY; i++) begin
            dv[i] <= dv[i-1];
            da[i] <= da[i-1];
            db[i] <= db[i-1];
         end
      end
   end

   assign wr_en_o     = dv[BF_LATENCY-1];
   assign wr_addr_a_o = da[BF_LATENCY-1];
   assign wr_addr_b_o = db[BF_LATENCY-1];
   assign stage_o     = s;

endmodule

// File: tb/tb_fft_sched.sv
// Directed bench for fft_sched: N=8 address table, start-while-busy, back-to-back, reset, latency sweep.
module tb_fft_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start8 = 1'b0, start4 = 1'b0, start16 = 1'b0;
   always #5 clk = ~clk;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   logic       busy8, done8, rd8, we8;
   logic [2:0] ra8, rb8, wa8, wb8, st8;
   logic [1:0] tw8;

   logic       busy4, done4, rd4, we4;
   logic [1:0] ra4, rb4, wa4, wb4, st4;
   logic [0:0] tw4;

   logic       busy16, done16, rd16, we16;
   logic [3:0] ra16, rb16, wa16, wb16;
   logic [2:0] tw16, st16;

   fft_sched #(.N_POINTS(8), .BF_LATENCY(3)) u8 (
      .clk(clk), .rst_n(rst_n), .start_i(start8), .busy_o(busy8), .done_o(done8),
      .rd_en_o(rd8), .rd_addr_a_o(ra8), .rd_addr_b_o(rb8), .tw_addr_o(tw8),
      .wr_en_o(we8), .wr_addr_a_o(wa8), .wr_addr_b_o(wb8), .stage_o(st8));

   fft_sched #(.N_POINTS(4), .BF_LATENCY(1)) u4 (
      .clk(clk), .rst_n(rst_n), .start_i(start4), .busy_o(busy4), .done_o(done4),
      .rd_en_o(rd4), .rd_addr_a_o(ra4), .rd_addr_b_o(rb4), .tw_addr_o(tw4),
      .wr_en_o(we4), .wr_addr_a_o(wa4), .wr_addr_b_o(wb4), .stage_o(st4));

   fft_sched #(.N_POINTS(16), .BF_LATENCY(5)) u16 (
      .clk(clk), .rst_n(rst_n), .start_i(start16), .busy_o(busy16), .done_o(done16),
      .rd_en_o(rd16), .rd_addr_a_o(ra16), .rd_addr_b_o(rb16), .tw_addr_o(tw16),
      .wr_en_o(we16), .wr_addr_a_o(wa16), .wr_addr_b_o(wb16), .stage_o(st16));

   logic [20:0] obs8;
   assign obs8 = {rd8, ra8, rb8, tw8, we8, wa8, wb8, done8, busy8, st8};

   logic [20:0] etab [1:23];

   function automatic logic [20:0] pk(input logic rd, input logic [2:0] a, input logic [2:0] b,
                                      input logic [1:0] tw, input logic we, input logic [2:0] wa,
                                      input logic [2:0] wb, input logic dn, input logic bsy,
                                      input logic [2:0] st);
      return {rd, a, b, tw, we, wa, wb, dn, bsy, st};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives one N=8 transform from IDLE and checks every cycle against the hand table.
   task automatic run8(input string tag, input bit pulses);
      start8 = 1'b1;
      tick();
      for (int c = 1; c <= 23; c++) begin
         start8 = (pulses && (c == 3 || c == 10)) ? 1'b1 : 1'b0;
         chk($sformatf("%s c%0d", tag, c), 64'(obs8), 64'(etab[c]));
         tick();
      end
      start8 = 1'b0;
   endtask

   // Hazard monitor on the N=8 instance: no read of a pending write, each address written once per stage.
   logic [7:0] pend;
   logic [1:0] wcnt [8];
   logic [2:0] pst;
   always @(negedge clk) begin
      if (!rst_n) begin
         pend <= '0;
         pst  <= '0;
         for (int i = 0; i < 8; i++) wcnt[i] <= '0;
      end else begin
         if (rd8) begin
            nvec++;
            assert (!pend[ra8] && !pend[rb8]) else begin
               nerr++;
               $error("FAIL raw_hazard: observed read %0d/%0d pending %b, expected no pending", ra8, rb8, pend);
            end
         end
         if ((st8 != pst && st8 != 3'd0) || done8) begin
            nvec++;
            for (int i = 0; i < 8; i++) begin
               assert (wcnt[i] == 2'd1) else begin
                  nerr++;
                  $error("FAIL write_once addr%0d: observed %0d writes, expected 1", i, wcnt[i]);
               end
               wcnt[i] <= '0;
            end
         end
         if (we8) begin
            nvec++;
            assert (wcnt[wa8] == 2'd0 && wcnt[wb8] == 2'd0) else begin
               nerr++;
               $error("FAIL double_write: observed counts %0d/%0d at %0d/%0d, expected 0/0",
                      wcnt[wa8], wcnt[wb8], wa8, wb8);
            end
            wcnt[wa8] <= wcnt[wa8] + 2'd1;
            wcnt[wb8] <= wcnt[wb8] + 2'd1;
         end
         pend <= (pend & ~(we8 ? ((8'd1 << wa8) | (8'd1 << wb8)) : 8'd0))
                 | (rd8 ? ((8'd1 << ra8) | (8'd1 << rb8)) : 8'd0);
         pst <= st8;
      end
   end

   int d4c, d4n, d16c, d16n;

   initial begin
      //                rd a  b  tw we wa wb dn bsy st
      etab[1]  = pk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      etab[2]  = pk(1, 2, 3, 0, 0, 0, 0, 0, 1, 0);
      etab[3]  = pk(1, 4, 5, 0, 0, 0, 0, 0, 1, 0);
      etab[4]  = pk(1, 6, 7, 0, 1, 0, 1, 0, 1, 0);
      etab[5]  = pk(0, 0, 0, 0, 1, 2, 3, 0, 1, 0);
      etab[6]  = pk(0, 0, 0, 0, 1, 4, 5, 0, 1, 0);
      etab[7]  = pk(0, 0, 0, 0, 1, 6, 7, 0, 1, 0);
      etab[8]  = pk(1, 0, 2, 0, 0, 0, 0, 0, 1, 1);
      etab[9]  = pk(1, 1, 3, 2, 0, 0, 0, 0, 1, 1);
      etab[10] = pk(1, 4, 6, 0, 0, 0, 0, 0, 1, 1);
      etab[11] = pk(1, 5, 7, 2, 1, 0, 2, 0, 1, 1);
      etab[12] = pk(0, 0, 0, 0, 1, 1, 3, 0, 1, 1);
      etab[13] = pk(0, 0, 0, 0, 1, 4, 6, 0, 1, 1);
      etab[14] = pk(0, 0, 0, 0, 1, 5, 7, 0, 1, 1);
      etab[15] = pk(1, 0, 4, 0, 0, 0, 0, 0, 1, 2);
      etab[16] = pk(1, 1, 5, 1, 0, 0, 0, 0, 1, 2);
      etab[17] = pk(1, 2, 6, 2, 0, 0, 0, 0, 1, 2);
      etab[18] = pk(1, 3, 7, 3, 1, 0, 4, 0, 1, 2);
      etab[19] = pk(0, 0, 0, 0, 1, 1, 5, 0, 1, 2);
      etab[20] = pk(0, 0, 0, 0, 1, 2, 6, 0, 1, 2);
      etab[21] = pk(0, 0, 0, 0, 1, 3, 7, 0, 1, 2);
      etab[22] = pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
      etab[23] = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      tick();
      chk("reset8", 64'(obs8), 64'd0);
      chk("reset4", 64'({busy4, done4, rd4, ra4, rb4, tw4, we4, wa4, wb4, st4}), 64'd0);
      chk("reset16", 64'({busy16, done16, rd16, ra16, rb16, tw16, we16, wa16, wb16, st16}), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("idle8", 64'(obs8), 64'd0);

      run8("stage_seq", 1'b0);
      chk("idle_after", 64'(obs8), 64'd0);

      run8("start_busy", 1'b1);

      // start held high: restart after exactly one IDLE cycle
      start8 = 1'b1;
      tick();
      for (int c = 1; c < 22; c++) tick();
      chk("b2b_done22", 64'(done8), 64'd1);
      tick();
      chk("b2b_idle23", 64'({busy8, rd8}), 64'd0);
      tick();
      chk("b2b_run24", 64'({busy8, rd8, ra8, rb8}), 64'({1'b1, 1'b1, 3'd0, 3'd1}));
      start8 = 1'b0;
      for (int i = 0; i < 30 && !done8; i++) tick();
      chk("b2b_second_done", 64'(done8), 64'd1);
      tick();

      // asynchronous reset in stage 1 with stage-1 reads still in the delay line
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (9) tick();
      chk("pre_rst c10", 64'({rd8, ra8, rb8, st8}), 64'({1'b1, 3'd4, 3'd6, 3'd1}));
      #2 rst_n = 1'b0;
      #1 chk("async_rst", 64'(obs8), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         chk($sformatf("no_wr_after_rst %0d", c), 64'({we8, busy8}), 64'd0);
         tick();
      end
      run8("after_rst", 1'b0);

      // latency sweep: N=4/L=1 done at 7, N=16/L=5 done at 53
      d4c = 0; d4n = 0; d16c = 0; d16n = 0;
      start4 = 1'b1;
      start16 = 1'b1;
      tick();
      start4 = 1'b0;
      start16 = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (done4) begin d4c = c; d4n++; end
         if (done16) begin d16c = c; d16n++; end
         if (c == 1) chk("sweep_first_rd", 64'({busy4, rd4, busy16, rd16}), 64'hF);
         if (c == 5) chk("n4_stage1_rd", 64'({rd4, ra4, rb4, tw4, st4}), 64'({1'b1, 2'd1, 2'd3, 1'b1, 2'd1}));
         if (c == 6) chk("n4_stage1_wr", 64'({we4, wa4, wb4, rd4}), 64'({1'b1, 2'd1, 2'd3, 1'b0}));
         if (c == 8) chk("n4_busy_fall", 64'(busy4), 64'd0);
         if (c == 54) chk("n16_busy_fall", 64'(busy16), 64'd0);
         tick();
      end
      chk("n4_done_cycle", 64'(d4c), 64'd7);
      chk("n4_done_pulses", 64'(d4n), 64'd1);
      chk("n16_done_cycle", 64'(d16c), 64'd53);
      chk("n16_done_pulses", 64'(d16n), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fft_sched.md
# fft_sched

Sequencer for the in-place radix-2 decimation-in-time FFT in the MFCC core. It walks all stages and butterflies of an N-point transform, one butterfly per cycle. For each butterfly it issues operand-pair read addresses and a twiddle ROM index to the pipelined complex butterfly datapath (Q1.31 `complex` add/sub/mul). It returns matching write-back addresses after the datapath latency and drains the pipeline between stages to avoid read-after-write hazards. Frame memory is preloaded in bit-reversed order by the windowing stage before `start_i`.

## Interface
- `N_POINTS`, 512: transform size; power of two, ≥ 4.
- `ADDR_W`, $clog2(N_POINTS): frame memory address width.
- `BF_LATENCY`, 3: cycles from read issue to write-back data valid at the datapath output; ≥ 1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin a transform; sampled only in IDLE.
- `busy_o` out 1: high from the cycle after start acceptance through the DONE cycle.
- `done_o` out 1: one-cycle pulse after the final write-back.
- `rd_en_o` out 1: butterfly read issue.
- `rd_addr_a_o` out ADDR_W: top operand address.
- `rd_addr_b_o` out ADDR_W: bottom operand address.
- `tw_addr_o` out ADDR_W-1: twiddle ROM index, for W_N^k.
- `wr_en_o` out 1: write-back strobe for both results.
- `wr_addr_a_o` out ADDR_W: write address for a+W·b.
- `wr_addr_b_o` out ADDR_W: write address for a−W·b.
- `stage_o` out $clog2(ADDR_W)+1: current stage index, debug/visibility only.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `start_i` = 1 → RUN; stage s=0, butterfly counter k=0.
  - `start_i` is ignored in all other states.
- **RUN:** each cycle `rd_en_o` = 1 and outputs are combinational from (s, k):
  - half = 1<<s, pos = k & (half−1), grp = k >> s.
  - `rd_addr_a_o` = grp·2·half + pos.
  - `rd_addr_b_o` = `rd_addr_a_o` + half.
  - `tw_addr_o` = pos << (ADDR_W−1−s).
  - k increments each cycle. After k = N/2−1 → DRAIN, with k cleared.
- **Write-back delay line:** a BF_LATENCY-deep shift register of {valid, addr_a, addr_b}.
  - `wr_en_o`, `wr_addr_a_o` and `wr_addr_b_o` equal the `rd_*` values from exactly BF_LATENCY cycles earlier.
  - The delay line shifts in every state, including DRAIN and DONE.
- **DRAIN:** `rd_en_o` = 0 for BF_LATENCY cycles, counted by the drain counter.
  - On the last drain cycle, if s < ADDR_W−1: s++, next state RUN.
  - Otherwise next state DONE.
- **DONE:** `done_o` = 1 for one cycle, then IDLE.
- **Width rules:**
  - All address arithmetic is unsigned ADDR_W.
  - `tw_addr_o` never exceeds N/2−1.
  - No address wraps for legal s, k.
- **Reset (any state, including mid-transform):**
  - FSM → IDLE; s, k and the drain counter cleared; delay-line valid bits cleared.
  - All outputs 0: `busy_o`, `done_o`, `rd_en_o`, `wr_en_o`, and all address and `stage_o` outputs.
  - No spurious `wr_en_o` after reset release.
- Idle outputs: `rd_en_o` = 0; address outputs held at 0.

## Timing
- **Start acceptance:** `start_i` sampled high in IDLE at edge 0.
  - First `rd_en_o` and `busy_o` = 1 appear in cycle 1.
- **Per stage:** N/2 RUN cycles + BF_LATENCY DRAIN cycles.
- **Stage boundary:**
  - The last write of a stage coincides with the last DRAIN cycle.
  - The first read of the next stage is the following cycle.
  - The memory must return data written on the previous edge; no bypass is required.
- **Done timing:** `done_o` is asserted in cycle ADDR_W·(N/2 + BF_LATENCY) + 1; `busy_o` falls the cycle after.
- **Back-to-back transforms:** `start_i` held high continuously restarts in the cycle after DONE returns to IDLE.
  - Minimum gap between transforms: one IDLE cycle.

## Test plan
- **Stage 0 addresses:** N_POINTS=8, BF_LATENCY=3, start pulse.
  - Reads (a,b,tw): (0,1,0), (2,3,0), (4,5,0), (6,7,0) in cycles 1–4.
  - Writes repeat the same pairs in cycles 4–7.
- **Stages 1 and 2:** same config.
  - Stage 1 reads (0,2,0), (1,3,2), (4,6,0), (5,7,2) in cycles 8–11.
  - Stage 2 reads (0,4,0), (1,5,1), (2,6,2), (3,7,3) in cycles 15–18.
  - `done_o` in cycle 22 only; `busy_o` low from cycle 23.
- **Golden model:** N=512, BF_LATENCY=3, bench memory + butterfly model.
  - Impulse at index 0 → all 512 bins equal.
  - Cosine at bin 5 → peaks at bins 5 and 507, all others within ±2 LSB of 0.
  - Total 9·259 + 1 = 2332 cycles to `done_o`.
- **Start while busy:** pulse `start_i` at cycles 3 and 10 of a transform → no effect; address sequence and `done_o` cycle unchanged.
- **Reset mid-operation:** drop `rst_n` in stage 1 RUN with writes in flight.
  - All outputs 0 immediately (asynchronous).
  - After release, zero `wr_en_o` pulses until the next start.
  - A fresh start completes normally.
- **Parameter sweep:** BF_LATENCY=1 with N=4 → `done_o` in cycle 7; N=16, BF_LATENCY=5 → `done_o` in cycle 53.
  - Assertions throughout: each address is written exactly once per stage; no stage reads an address with a pending write.
